// File: rtl/tag_array_ctrl.sv
// Controller for a 1R/1W tag SRAM: post-reset/flush invalidate sweep, pipelined 8-way
// lookups with a registered compare stage, and masked per-way fills.
module tag_array_ctrl #(
  parameter int unsigned NSETS   = 64,
  parameter int unsigned NWAYS   = 8,
  parameter int unsigned ENTRY_W = 23,
  localparam int unsigned AW     = $clog2(NSETS),
  localparam int unsigned TW     = ENTRY_W - 1,
  localparam int unsigned DW     = NWAYS * ENTRY_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    req_set,
  input  logic [TW-1:0]    req_tag,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [NWAYS-1:0] resp_hit_oh,
  output logic             resp_multi_hit,
  output logic [DW-1:0]    resp_tags,
  input  logic             fill_valid,
  output logic             fill_ready,
  input  logic [AW-1:0]    fill_set,
  input  logic [NWAYS-1:0] fill_way_mask,
  input  logic [TW-1:0]    fill_tag,
  input  logic             fill_vbit,
  input  logic             flush_valid,
  output logic             flush_ready,
  output logic             init_done,
  output logic [AW-1:0]    mem_R0_addr,
  output logic             mem_R0_en,
  input  logic [DW-1:0]    mem_R0_data,
  output logic [AW-1:0]    mem_W0_addr,
  output logic             mem_W0_en,
  output logic [DW-1:0]    mem_W0_data,
  output logic [NWAYS-1:0] mem_W0_mask
);

  typedef enum logic {StInit, StRun} state_e;

  state_e            r_state, w_state_next;
  logic [AW-1:0]     r_cnt, w_cnt_next;
  logic              r_lk_v;
  logic [TW-1:0]     r_lk_tag;
  logic              r_resp_v;
  logic              r_hit;
  logic              r_multi;
  logic [NWAYS-1:0]  r_hit_oh;
  logic [DW-1:0]     r_tags;
  logic [NWAYS-1:0]  w_hit_oh;
  logic              w_multi;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StInit;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    req_ready    = 1'b0;
    fill_ready   = 1'b0;
    flush_ready  = 1'b0;
    init_done    = 1'b0;
    mem_R0_en    = 1'b0;
    mem_R0_addr  = '0;
    mem_W0_en    = 1'b0;
    mem_W0_addr  = '0;
    mem_W0_data  = '0;
    mem_W0_mask  = '0;
    unique case (r_state)
      StInit: begin
        mem_W0_en   = 1'b1;
        mem_W0_addr = r_cnt;
        mem_W0_mask = '1;
        w_cnt_next  = r_cnt + 1'b1;
        if (r_cnt == AW'(NSETS - 1)) w_state_next = StRun;
      end
      StRun: begin
        init_done   = 1'b1;
        flush_ready = 1'b1;
        if (flush_valid) begin
          w_state_next = StInit;
          w_cnt_next   = '0;
        end else begin
          fill_ready = 1'b1;
          // Same-set fill wins so the retried lookup observes the new entry.
          req_ready  = !(fill_valid && (fill_set == req_set));
          if (fill_valid) begin
            mem_W0_en   = |fill_way_mask;
            mem_W0_addr = fill_set;
            mem_W0_mask = fill_way_mask;
            mem_W0_data = {NWAYS{fill_vbit, fill_tag}};
          end
          if (req_valid && req_ready) begin
            mem_R0_en   = 1'b1;
            mem_R0_addr = req_set;
          end
        end
      end
      default: ;
    endcase
    if (reset) begin
      req_ready   = 1'b0;
      fill_ready  = 1'b0;
      flush_ready = 1'b0;
      init_done   = 1'b0;
      mem_R0_en   = 1'b0;
      mem_R0_addr = '0;
      mem_W0_en   = 1'b0;
      mem_W0_addr = '0;
      mem_W0_data = '0;
      mem_W0_mask = '0;
    end
  end

  always_comb begin
    w_hit_oh = '0;
    for (int i = 0; i < NWAYS; i++) begin
      w_hit_oh[i] = mem_R0_data[i*ENTRY_W + TW] &&
                    (mem_R0_data[i*ENTRY_W +: TW] == r_lk_tag);
    end
    w_multi = (w_hit_oh & (w_hit_oh - NWAYS'(1))) != '0;
  end

  // Lookup pipeline is independent of the FSM so in-flight lookups survive a flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lk_v   <= 1'b0;
      r_lk_tag <= '0;
      r_resp_v <= 1'b0;
      r_hit    <= 1'b0;
      r_multi  <= 1'b0;
      r_hit_oh <= '0;
      r_tags   <= '0;
    end else begin
      r_lk_v   <= mem_R0_en;
      if (mem_R0_en) r_lk_tag <= req_tag;
      r_resp_v <= r_lk_v;
      if (r_lk_v) begin
        r_hit    <= |w_hit_oh;
        r_multi  <= w_multi;
        r_hit_oh <= w_hit_oh;
        r_tags   <= mem_R0_data;
      end
    end
  end

  assign resp_valid     = r_resp_v;
  assign resp_hit       = r_hit;
  assign resp_multi_hit = r_multi;
  assign resp_hit_oh    = r_hit_oh;
  assign resp_tags      = r_tags;

endmodule

// File: tb/tb_tag_array_ctrl.sv
// Self-checking bench for tag_array_ctrl: behavioural SRAM, set/way reference model, directed
// scenarios followed by randomized traffic.
module tb_tag_array_ctrl;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0, req_ready;
  logic [5:0]   req_set = '0;
  logic [21:0]  req_tag = '0;
  logic         resp_valid, resp_hit, resp_multi_hit;
  logic [7:0]   resp_hit_oh;
  logic [183:0] resp_tags;
  logic         fill_valid = 1'b0, fill_ready;
  logic [5:0]   fill_set = '0;
  logic [7:0]   fill_way_mask = '0;
  logic [21:0]  fill_tag = '0;
  logic         fill_vbit = 1'b0;
  logic         flush_valid = 1'b0, flush_ready, init_done;
  logic [5:0]   mem_R0_addr, mem_W0_addr;
  logic         mem_R0_en, mem_W0_en;
  logic [183:0] mem_R0_data, mem_W0_data;
  logic [7:0]   mem_W0_mask;

  tag_array_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_hit_oh(resp_hit_oh),
    .resp_multi_hit(resp_multi_hit), .resp_tags(resp_tags),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_set(fill_set),
    .fill_way_mask(fill_way_mask), .fill_tag(fill_tag), .fill_vbit(fill_vbit),
    .flush_valid(flush_valid), .flush_ready(flush_ready), .init_done(init_done),
    .mem_R0_addr(mem_R0_addr), .mem_R0_en(mem_R0_en), .mem_R0_data(mem_R0_data),
    .mem_W0_addr(mem_W0_addr), .mem_W0_en(mem_W0_en), .mem_W0_data(mem_W0_data),
    .mem_W0_mask(mem_W0_mask)
  );

  always #5 clock = ~clock;

  // Tag macro: masked write, registered read address.
  logic [183:0] sram [64];
  logic [5:0]   rd_addr_q = '0;
  always @(posedge clock) begin
    logic [183:0] nw;
    if (mem_W0_en) begin
      nw = sram[mem_W0_addr];
      for (int w = 0; w < 8; w++) if (mem_W0_mask[w]) nw[w*23 +: 23] = mem_W0_data[w*23 +: 23];
      sram[mem_W0_addr] <= nw;
    end
    if (mem_R0_en) rd_addr_q <= mem_R0_addr;
  end
  assign mem_R0_data = sram[rd_addr_q];

  typedef struct {
    int           due;
    logic         hit;
    logic [7:0]   oh;
    logic         multi;
    logic [183:0] tags;
  } exp_t;

  logic        mv [64][8];
  logic [21:0] mt [64][8];
  exp_t        exp_q[$];
  exp_t        last;
  int          n_checks = 0, n_err = 0;
  int          cyc = 0, sweep_left = 0, sweep_addr = 0;

  task automatic chk(input string tag, input logic [183:0] obs, input logic [183:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_lookup(int s, logic [21:0] t, int due);
    exp_t e;
    int   n = 0;
    e.due = due; e.oh = '0; e.tags = '0;
    for (int w = 0; w < 8; w++) begin
      e.tags[w*23 +: 23] = {mv[s][w], mt[s][w]};
      if (mv[s][w] && mt[s][w] == t) begin e.oh[w] = 1'b1; n++; end
    end
    e.hit = (n > 0); e.multi = (n > 1);
    return e;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 64; s++) for (int w = 0; w < 8; w++) begin mv[s][w] = 1'b0; mt[s][w] = '0; end
    sweep_left = 64; sweep_addr = 0;
  endtask

  task automatic idle();
    req_valid = 1'b0; fill_valid = 1'b0; flush_valid = 1'b0;
  endtask

  task automatic rst_chk();
    chk("rst_outs", {mem_W0_en, mem_R0_en, resp_valid, req_ready, fill_ready, flush_ready,
                     init_done}, 0);
    chk("rst_resp", {resp_hit, resp_hit_oh}, 0);
  endtask

  // One clock: check at negedge, then advance the model at the posedge.
  task automatic cycle();
    logic acc_fill = 1'b0, acc_req = 1'b0, acc_flush = 1'b0, e_req_rdy;
    logic [183:0] wd;
    exp_t e;
    @(negedge clock);
    if (sweep_left > 0) begin
      chk("sweep_en", mem_W0_en, 1);
      chk("sweep_addr", mem_W0_addr, sweep_addr);
      chk("sweep_mask", mem_W0_mask, 8'hFF);
      chk("sweep_data", mem_W0_data, 0);
      chk("init_rdy", {init_done, req_ready, fill_ready, flush_ready, mem_R0_en}, 0);
    end else begin
      e_req_rdy = !flush_valid && !(fill_valid && fill_set == req_set);
      chk("run_rdy", {init_done, flush_ready, fill_ready, req_ready}, {1'b1, 1'b1, !flush_valid,
          e_req_rdy});
      acc_flush = flush_valid;
      acc_fill  = fill_valid && !flush_valid;
      acc_req   = req_valid && e_req_rdy;
      chk("w0_en", mem_W0_en, acc_fill && fill_way_mask != 0);
      if (acc_fill && fill_way_mask != 0) begin
        for (int w = 0; w < 8; w++) wd[w*23 +: 23] = {fill_vbit, fill_tag};
        chk("w0_addr", mem_W0_addr, fill_set);
        chk("w0_mask", mem_W0_mask, fill_way_mask);
        chk("w0_data", mem_W0_data, wd);
      end
      chk("r0_en", mem_R0_en, acc_req);
      if (acc_req) chk("r0_addr", mem_R0_addr, req_set);
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("resp_valid", resp_valid, 1);
      chk("resp_hit", resp_hit, e.hit);
      chk("resp_oh", resp_hit_oh, e.oh);
      chk("resp_multi", resp_multi_hit, e.multi);
      chk("resp_tags", resp_tags, e.tags);
      last = e;
    end else begin
      chk("resp_idle", resp_valid, 0);
      chk("resp_hold", {resp_hit, resp_hit_oh}, {last.hit, last.oh});
    end
    if (acc_req) exp_q.push_back(model_lookup(int'(req_set), req_tag, cyc + 2));
    @(posedge clock);
    if (sweep_left > 0) begin
      sweep_left--; sweep_addr++;
    end else if (acc_flush) begin
      model_clear();
    end else if (acc_fill) begin
      for (int w = 0; w < 8; w++)
        if (fill_way_mask[w]) begin mv[fill_set][w] = fill_vbit; mt[fill_set][w] = fill_tag; end
    end
    cyc++;
    #1;
  endtask

  task automatic set_fill(input int s, input logic [7:0] m, input logic [21:0] t, input logic v);
    fill_valid = 1'b1; fill_set = 6'(s); fill_way_mask = m; fill_tag = t; fill_vbit = v;
  endtask

  task automatic set_req(input int s, input logic [21:0] t);
    req_valid = 1'b1; req_set = 6'(s); req_tag = t;
  endtask

  initial begin
    for (int s = 0; s < 64; s++)
      for (int k = 0; k < 184; k++) sram[s][k] = 1'($urandom_range(1));
    last = '{0, 1'b0, 8'h00, 1'b0, '0};
    model_clear();
    @(negedge clock); rst_chk();
    @(posedge clock); #1 reset = 1'b0;

    // Sweep plus first RUN cycle.
    repeat (65) cycle();

    // Single-way hit, then misses on a near tag and on invalid tag-0 entries.
    set_fill(5, 8'h04, 22'h12345, 1'b1); cycle(); idle();
    set_req(5, 22'h12345); cycle(); idle(); cycle(); cycle();
    chk("t2_hit_oh", {resp_hit, resp_hit_oh}, {1'b1, 8'h04});
    set_req(5, 22'h12346); cycle(); set_req(5, 22'h0); cycle(); idle(); cycle(); cycle();
    chk("t3_miss", {resp_hit, resp_hit_oh}, 0);

    // Same-set collision blocks the lookup; different sets proceed together.
    set_fill(9, 8'h10, 22'h2AAAA, 1'b1); set_req(9, 22'h2AAAA); cycle(); idle();
    set_req(9, 22'h2AAAA); cycle(); idle(); cycle(); cycle();
    chk("t4_retry", resp_hit_oh, 8'h10);
    set_fill(9, 8'h01, 22'h1BBBB, 1'b1); set_req(10, 22'h2AAAA); cycle(); idle(); cycle(); cycle();

    // Multi-hit, then invalidate one of the ways.
    set_fill(3, 8'h81, 22'h3CCCC, 1'b1); cycle(); idle();
    set_req(3, 22'h3CCCC); cycle(); idle(); cycle(); cycle();
    chk("t5_multi", {resp_multi_hit, resp_hit_oh}, {1'b1, 8'h81});
    set_fill(3, 8'h80, 22'h3CCCC, 1'b0); cycle(); idle();
    set_req(3, 22'h3CCCC); cycle(); idle(); cycle(); cycle();
    chk("t5_single", {resp_multi_hit, resp_hit_oh}, {1'b0, 8'h01});

    // Flush behind an in-flight lookup; afterwards everything misses.
    set_req(5, 22'h12345); cycle(); idle();
    flush_valid = 1'b1; cycle(); idle();
    repeat (65) cycle();
    chk("t6_inflight", resp_hit_oh, 8'h04);
    set_req(5, 22'h12345); cycle(); set_req(3, 22'h3CCCC); cycle();
    set_req(9, 22'h2AAAA); cycle(); idle(); cycle(); cycle();
    chk("t6_miss", {resp_hit, resp_hit_oh}, 0);

    // Asynchronous reset with a lookup in flight drops the response.
    set_fill(7, 8'h02, 22'h00777, 1'b1); cycle(); idle();
    set_req(7, 22'h00777); cycle(); idle();
    reset = 1'b1;
    #1 rst_chk();
    @(negedge clock); rst_chk();
    exp_q.delete(); last = '{0, 1'b0, 8'h00, 1'b0, '0};
    model_clear();
    @(posedge clock); #1 reset = 1'b0;
    repeat (66) cycle();

    // Randomized traffic on a few sets and tags to provoke hits and collisions.
    for (int i = 0; i < 600; i++) begin
      req_valid   = 1'($urandom_range(0, 9) < 6);
      req_set     = 6'($urandom_range(0, 7));
      req_tag     = 22'h100 + 22'($urandom_range(0, 3));
      fill_valid  = 1'($urandom_range(0, 1));
      fill_set    = 6'($urandom_range(0, 7));
      fill_way_mask = 8'($urandom_range(0, 255)) & (1'($urandom_range(0, 7) == 0) ? 8'h00 : 8'hFF);
      fill_tag    = 22'h100 + 22'($urandom_range(0, 3));
      fill_vbit   = 1'($urandom_range(0, 3) != 0);
      flush_valid = 1'($urandom_range(0, 199) == 0);
      cycle();
    end
    idle();
    repeat (70) cycle();
    chk("q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/tag_array_ctrl.md
Name: tag_array_ctrl

Overview:
- Initiator-side controller for the 64-set x 8-way x 23-bit tag SRAM macro (1R/1W, 1-cycle registered-address read, 8-bit per-way write mask).
- Drives the macro's R0/W0 ports: invalidates every set after reset or flush, services tag lookups (read + 8-way compare), and services fills (masked per-way writes).
- Sits between the cache pipeline and the tag macro; the macro's clocks are tied to clock externally.

Parameters:
- NSETS, 64, number of sets; address width is log2(NSETS) = 6.
- NWAYS, 8, ways per set; one write-mask bit per way.
- ENTRY_W, 23, bits per way entry: bit 22 = valid, bits 21:0 = tag.

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high
- req_valid  in  1  lookup request
- req_ready  out  1  lookup accepted when valid&ready
- req_set  in  6  lookup set index
- req_tag  in  22  lookup tag
- resp_valid  out  1  lookup result valid (no backpressure)
- resp_hit  out  1  at least one way matched
- resp_hit_oh  out  8  per-way match vector
- resp_multi_hit  out  1  more than one way matched (error flag)
- resp_tags  out  184  raw set contents read
- fill_valid  in  1  fill request
- fill_ready  out  1  fill accepted when valid&ready
- fill_set  in  6  fill set index
- fill_way_mask  in  8  ways to write
- fill_tag  in  22  tag to write
- fill_vbit  in  1  valid bit to write (0 = invalidate)
- flush_valid  in  1  request a full invalidate sweep
- flush_ready  out  1  flush accepted when valid&ready
- init_done  out  1  high only in RUN
- mem_R0_addr  out  6,  mem_R0_en  out  1,  mem_R0_data  in  184
- mem_W0_addr  out  6,  mem_W0_en  out  1,  mem_W0_data  out  184,  mem_W0_mask  out  8

Behaviour:
- States: INIT, RUN. Reset → INIT with sweep counter = 0. All outputs 0 during reset; init_done = 0.
- INIT: each cycle, write set = counter, mask = 0xFF, data = 0; counter increments. The cycle that writes set 63 transitions to RUN. The sweep takes exactly 64 cycles; init_done rises in the following cycle.
- In INIT, req_ready, fill_ready and flush_ready are all 0.
- RUN, flush: flush_ready = 1. An accepted flush forces req_ready = fill_ready = 0 that cycle; next cycle → INIT with counter = 0.
- Priority in RUN: flush > fill > lookup.
- RUN, lookup: accepted in cycle t drives mem_R0_en = 1 and mem_R0_addr = req_set in cycle t. In cycle t+1, the controller compares each way i: entry[22] & (entry[21:0] == stored req_tag). Results are registered, so resp_* are valid in cycle t+2 with resp_valid = 1 for exactly one cycle. Throughput is 1 lookup/cycle.
- RUN, fill: accepted in cycle t drives mem_W0_en = 1, mem_W0_addr = fill_set, and mem_W0_mask = fill_way_mask in cycle t. mem_W0_data replicates {fill_vbit, fill_tag} 8 times. A zero mask is accepted and drives mem_W0_en = 0.
- Hazard: if fill_valid and req_valid target the same set in the same cycle, the fill proceeds and req_ready = 0. A lookup in the next cycle sees the new data. Lookup and fill to different sets are accepted together.
- In-flight lookups accepted before a flush still complete; their responses reflect pre-flush data.
- resp_* hold their last values while resp_valid = 0. mem_R0_en / mem_W0_en are 0 whenever idle.
- An asynchronous reset mid-sweep or mid-lookup aborts everything: the in-flight response is dropped and the sweep restarts at 0.

Test Plan:
- Reset release → mem_W0_en = 1 for exactly 64 cycles, addresses 0..63, mask 0xFF, data 0; init_done = 1 in cycle 65; no ready asserted before that.
- Fill set 5, mask 0x04, tag 0x12345, vbit 1; lookup set 5 tag 0x12345 → resp_hit = 1, resp_hit_oh = 0x04, resp_valid two cycles after acceptance.
- Lookup set 5 tag 0x12346 → resp_hit = 0, resp_hit_oh = 0; the valid=0 entry with tag 0 does not hit tag 0.
- Same-cycle fill set 9 and lookup set 9 → req_ready = 0; the lookup retried next cycle hits the new tag. Fill set 9 with lookup set 10 → both accepted.
- Fill set 3 with mask 0x81 and the same tag → resp_hit_oh = 0x81, resp_multi_hit = 1. A later fill with vbit 0 to way 7 → hit_oh = 0x01.
- Flush accepted with a lookup in flight → the lookup response is still delivered; 64 sweep cycles follow; all later lookups miss.
